// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: pipelined instruction-fetch front end with a PC tag queue, an
// instruction FIFO and redirect flush. Define FETCH_PERF_COUNTERS_EN to add starve/stall counters.
module fetch_queue_unit #(
   parameter int               XLEN            = 64,
   parameter int               ILEN            = 32,
   parameter int               FIFO_DEPTH      = 4,
   parameter int               MAX_OUTSTANDING = 2,
   parameter logic [XLEN-1:0]  RESET_PC        = {XLEN{1'b0}}
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             redirect_valid,
   input  logic [XLEN-1:0]  redirect_pc,
   output logic             imem_req_valid,
   input  logic             imem_req_ready,
   output logic [XLEN-1:0]  imem_req_addr,
   input  logic             imem_resp_valid,
   input  logic [ILEN-1:0]  imem_resp_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_pc,
   output logic [ILEN-1:0]  out_instr
`ifdef FETCH_PERF_COUNTERS_EN
   ,
   output logic [31:0]      perf_starve_cycles,
   output logic [31:0]      perf_stall_cycles
`endif
);
   localparam int FPW = $clog2(FIFO_DEPTH);
   localparam int TPW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int CW  = $clog2(FIFO_DEPTH + MAX_OUTSTANDING + 1) + 2;

   logic [XLEN-1:0] fetch_pc_r;
   logic [XLEN-1:0] fifo_pc_r    [FIFO_DEPTH];
   logic [ILEN-1:0] fifo_instr_r [FIFO_DEPTH];
   logic [FPW-1:0]  fifo_rd_r;
   logic [FPW-1:0]  fifo_wr_r;
   logic [CW-1:0]   fifo_cnt_r;
   logic [CW-1:0]   outstanding_r;
   logic [CW-1:0]   drop_r;
   logic [XLEN-1:0] tag_pc_r [MAX_OUTSTANDING];
   logic [TPW-1:0]  tag_rd_r;
   logic [TPW-1:0]  tag_wr_r;

   logic            fire_s;
   logic            resp_any_s;
   logic            resp_take_s;
   logic            push_s;
   logic            pop_s;
   logic [CW-1:0]   credit_s;

   function automatic logic [TPW-1:0] tag_next(input logic [TPW-1:0] p);
      if (p == TPW'(MAX_OUTSTANDING - 1)) begin
         return {TPW{1'b0}};
      end else begin
         return p + TPW'(1'b1);
      end
   endfunction

   // Issue credit and handshake qualification, from registered state only.
   always_comb begin
      credit_s       = fifo_cnt_r + outstanding_r + drop_r;
      imem_req_valid = !rst && !redirect_valid
                       && (outstanding_r < CW'(MAX_OUTSTANDING))
                       && (credit_s < CW'(FIFO_DEPTH));
      imem_req_addr  = fetch_pc_r;
      fire_s         = imem_req_valid && imem_req_ready;
      // A response with nothing in flight (drop and outstanding both zero) is ignored.
      resp_any_s     = imem_resp_valid && ((drop_r != {CW{1'b0}}) || (outstanding_r != {CW{1'b0}}));
      resp_take_s    = imem_resp_valid && (drop_r == {CW{1'b0}}) && (outstanding_r != {CW{1'b0}});
      push_s         = resp_take_s && !redirect_valid;
      out_valid      = (fifo_cnt_r != {CW{1'b0}});
      pop_s          = out_valid && out_ready && !redirect_valid;
   end

   // Head of the instruction queue, forced to zero while the queue is empty.
   always_comb begin
      if (out_valid) begin
         out_pc    = fifo_pc_r[fifo_rd_r];
         out_instr = fifo_instr_r[fifo_rd_r];
      end else begin
         out_pc    = {XLEN{1'b0}};
         out_instr = {ILEN{1'b0}};
      end
   end

   // Fetch PC, in-flight accounting and the PC tag queue.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_r    <= RESET_PC;
         outstanding_r <= {CW{1'b0}};
         drop_r        <= {CW{1'b0}};
         tag_rd_r      <= {TPW{1'b0}};
         tag_wr_r      <= {TPW{1'b0}};
      end else if (redirect_valid) begin
         // Everything still in flight becomes a response to be discarded.
         fetch_pc_r    <= redirect_pc;
         drop_r        <= drop_r + outstanding_r - CW'(resp_any_s);
         outstanding_r <= {CW{1'b0}};
         tag_rd_r      <= {TPW{1'b0}};
         tag_wr_r      <= {TPW{1'b0}};
      end else begin
         if (fire_s) begin
            fetch_pc_r         <= fetch_pc_r + XLEN'(3'd4);
            tag_pc_r[tag_wr_r] <= fetch_pc_r;
            tag_wr_r           <= tag_next(tag_wr_r);
         end
         if (resp_take_s) begin
            tag_rd_r <= tag_next(tag_rd_r);
         end
         if (imem_resp_valid && (drop_r != {CW{1'b0}})) begin
            drop_r <= drop_r - CW'(1'b1);
         end
         outstanding_r <= outstanding_r + CW'(fire_s) - CW'(resp_take_s);
      end
   end

   // Instruction FIFO storage and pointers.
   always_ff @(posedge clk) begin
      if (rst || redirect_valid) begin
         fifo_rd_r  <= {FPW{1'b0}};
         fifo_wr_r  <= {FPW{1'b0}};
         fifo_cnt_r <= {CW{1'b0}};
      end else begin
         if (push_s) begin
            fifo_pc_r[fifo_wr_r]    <= tag_pc_r[tag_rd_r];
            fifo_instr_r[fifo_wr_r] <= imem_resp_data;
            fifo_wr_r               <= fifo_wr_r + FPW'(1'b1);
         end
         if (pop_s) begin
            fifo_rd_r <= fifo_rd_r + FPW'(1'b1);
         end
         fifo_cnt_r <= fifo_cnt_r + CW'(push_s) - CW'(pop_s);
      end
   end

`ifdef FETCH_PERF_COUNTERS_EN
   // Saturating starve/stall counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_starve_cycles <= 32'd0;
         perf_stall_cycles  <= 32'd0;
      end else begin
         if (out_ready && !out_valid && (perf_starve_cycles != {32{1'b1}})) begin
            perf_starve_cycles <= perf_starve_cycles + 32'd1;
         end
         if (imem_req_valid && !imem_req_ready && (perf_stall_cycles != {32{1'b1}})) begin
            perf_stall_cycles <= perf_stall_cycles + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb_fetch_queue_unit: directed phases plus randomized traffic against a queue-based
// reference model of the fetch front end and an in-order variable-latency memory.
module tb_fetch_queue_unit;
   localparam int          XLEN   = 64;
   localparam int          ILEN   = 32;
   localparam int          DEPTH  = 4;
   localparam int          MAXO   = 2;
   localparam logic [63:0] RST_PC = 64'hFFFF_FFFF_FFFF_FFFC;

   logic             clk = 1'b0;
   logic             rst;
   logic             redirect_valid;
   logic [XLEN-1:0]  redirect_pc;
   logic             imem_req_valid;
   logic             imem_req_ready;
   logic [XLEN-1:0]  imem_req_addr;
   logic             imem_resp_valid;
   logic [ILEN-1:0]  imem_resp_data;
   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  out_pc;
   logic [ILEN-1:0]  out_instr;
`ifdef FETCH_PERF_COUNTERS_EN
   logic [31:0]      perf_starve_cycles;
   logic [31:0]      perf_stall_cycles;
`endif

   always #5 clk = ~clk;

   fetch_queue_unit #(
      .XLEN(XLEN), .ILEN(ILEN), .FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(RST_PC)
   ) dut (
      .clk(clk), .rst(rst),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
      .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr)
`ifdef FETCH_PERF_COUNTERS_EN
      , .perf_starve_cycles(perf_starve_cycles), .perf_stall_cycles(perf_stall_cycles)
`endif
   );

   typedef struct { logic [63:0] pc; bit killed; } flight_t;
   typedef struct { logic [63:0] pc; logic [31:0] instr; } entry_t;
   typedef struct { logic [63:0] addr; int due; } mreq_t;

   flight_t     flight_q[$];
   entry_t      fifo_q[$];
   mreq_t       mem_q[$];
   logic [63:0] m_pc;
   logic [31:0] m_starve;
   logic [31:0] m_stall;
   int          cyc;
   int          checks;
   int          errors;
   int          lat_min;
   int          lat_max;

   function automatic logic [31:0] mem_data(input logic [63:0] addr);
      return addr[33:2] ^ addr[63:32] ^ 32'h5A3C_9E17;
   endfunction

   function automatic int live_cnt();
      int n = 0;
      foreach (flight_q[i]) if (!flight_q[i].killed) n++;
      return n;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // One clock cycle: drive inputs, check outputs at negedge, advance model and memory.
   task automatic step(input bit rst_i, input bit redir_i, input logic [63:0] rpc_i,
                       input bit rdy_i, input bit ordy_i);
      bit          resp_v;
      logic [31:0] resp_d;
      bit          exp_rv;
      bit          exp_ov;
      bit          dut_fire;
      logic [63:0] dut_addr;
      flight_t     f;
      rst = rst_i; redirect_valid = redir_i; redirect_pc = rpc_i;
      imem_req_ready = rdy_i; out_ready = ordy_i;
      resp_v = 1'b0; resp_d = 32'd0;
      if (!rst_i && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
         resp_v = 1'b1;
         resp_d = mem_data(mem_q[0].addr);
      end
      imem_resp_valid = resp_v; imem_resp_data = resp_d;
      @(negedge clk);
      exp_rv = !rst_i && !redir_i && (live_cnt() < MAXO) && (fifo_q.size() + flight_q.size() < DEPTH);
      exp_ov = (fifo_q.size() > 0);
      chk("req_valid", 64'(imem_req_valid), 64'(exp_rv));
      chk("req_addr", imem_req_addr, m_pc);
      chk("out_valid", 64'(out_valid), 64'(exp_ov));
      if (exp_ov) begin
         chk("out_pc", out_pc, fifo_q[0].pc);
         chk("out_instr", 64'(out_instr), 64'(fifo_q[0].instr));
      end
`ifdef FETCH_PERF_COUNTERS_EN
      chk("perf_starve", 64'(perf_starve_cycles), 64'(m_starve));
      chk("perf_stall", 64'(perf_stall_cycles), 64'(m_stall));
`endif
      dut_fire = imem_req_valid && imem_req_ready;
      dut_addr = imem_req_addr;
      @(posedge clk);
      cyc++;
      if (rst_i) begin
         m_pc = RST_PC; flight_q.delete(); fifo_q.delete(); mem_q.delete();
         m_starve = 32'd0; m_stall = 32'd0;
      end else begin
         if (ordy_i && !exp_ov && m_starve != 32'hFFFF_FFFF) m_starve++;
         if (exp_rv && !rdy_i && m_stall != 32'hFFFF_FFFF) m_stall++;
         if (redir_i) begin
            if (resp_v && flight_q.size() > 0) void'(flight_q.pop_front());
            foreach (flight_q[i]) flight_q[i].killed = 1'b1;
            fifo_q.delete();
            m_pc = rpc_i;
         end else begin
            if (exp_ov && ordy_i) void'(fifo_q.pop_front());
            if (resp_v && flight_q.size() > 0) begin
               f = flight_q.pop_front();
               if (!f.killed) fifo_q.push_back('{pc: f.pc, instr: resp_d});
            end
            if (exp_rv && rdy_i) begin
               flight_q.push_back('{pc: m_pc, killed: 1'b0});
               m_pc = m_pc + 64'd4;
            end
         end
         if (resp_v) void'(mem_q.pop_front());
         if (dut_fire) mem_q.push_back('{addr: dut_addr, due: cyc - 1 + $urandom_range(lat_max, lat_min)});
      end
      #1;
   endtask

   initial begin
      logic [63:0] prev_pc;
      logic [63:0] held;
      logic [63:0] tgt;
      bit          seen;
      rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 64'd0; imem_req_ready = 1'b0;
      imem_resp_valid = 1'b0; imem_resp_data = 32'd0; out_ready = 1'b0;
      checks = 0; errors = 0; cyc = 0; lat_min = 1; lat_max = 1;
      m_pc = RST_PC; m_starve = 32'd0; m_stall = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_pc", out_pc, 64'd0);
      chk("rst_out_instr", 64'(out_instr), 64'd0);
      chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
      chk("rst_fetch_pc", imem_req_addr, RST_PC);
      step(1'b1, 1'b0, 64'd0, 1'b1, 1'b1);

      // Streaming from a reset PC at the top of the address space: wrap to 0.
      step(1'b0, 1'b0, 64'd0, 1'b1, 1'b1);
      chk("wrap_addr", imem_req_addr, 64'd0);
      repeat (3) step(1'b0, 1'b0, 64'd0, 1'b1, 1'b1);
      prev_pc = out_pc;
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 1'b0, 64'd0, 1'b1, 1'b1);
         chk("steady_valid", 64'(out_valid), 64'd1);
         chk("steady_pc", out_pc, prev_pc + 64'd4);
         prev_pc = out_pc;
      end

      // Redirect to 0 while decode is stalled: FIFO fills with 0x0..0xC and fetch stops.
      step(1'b0, 1'b1, 64'd0, 1'b1, 1'b0);
      repeat (10) step(1'b0, 1'b0, 64'd0, 1'b1, 1'b0);
      chk("full_req_valid", 64'(imem_req_valid), 64'd0);
      chk("full_head_pc", out_pc, 64'd0);
      chk("full_fetch_pc", imem_req_addr, 64'h10);
      repeat (8) step(1'b0, 1'b0, 64'd0, 1'b1, 1'b1);

      // Two-cycle memory builds two outstanding requests, then redirect to 0x100.
      lat_min = 2; lat_max = 2;
      repeat (6) step(1'b0, 1'b0, 64'd0, 1'b1, 1'b1);
      step(1'b0, 1'b1, 64'h100, 1'b1, 1'b1);
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 1'b0, 64'd0, 1'b1, 1'b1);
         if (!seen && out_valid) begin
            seen = 1'b1;
            chk("redir_first_pc", out_pc, 64'h100);
         end
      end
      chk("redir_seen", 64'(seen), 64'd1);

      // Memory not ready for three cycles: address holds.
      lat_min = 1; lat_max = 1;
      held = imem_req_addr;
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 64'd0, 1'b0, 1'b1);
         chk("hold_addr", imem_req_addr, held);
      end
      repeat (6) step(1'b0, 1'b0, 64'd0, 1'b1, 1'b1);

      // Randomized traffic.
      lat_min = 1; lat_max = 3;
      for (int i = 0; i < 3000; i++) begin
         case ($urandom_range(2, 0))
            0:       tgt = 64'h100;
            1:       tgt = 64'hFFFF_FFFF_FFFF_FFF8;
            default: tgt = {$urandom(), $urandom()} & ~64'h3;
         endcase
         step(($urandom_range(199, 0) == 0), ($urandom_range(24, 0) == 0), tgt,
              ($urandom_range(3, 0) != 0), ($urandom_range(2, 0) != 0));
      end

      // Reset while busy: everything discarded, fetch restarts at the reset PC.
      lat_min = 3; lat_max = 3;
      step(1'b0, 1'b1, 64'h200, 1'b1, 1'b0);
      repeat (6) step(1'b0, 1'b0, 64'd0, 1'b1, 1'b0);
      step(1'b1, 1'b0, 64'd0, 1'b1, 1'b0);
      chk("rst2_out_valid", 64'(out_valid), 64'd0);
      chk("rst2_req_valid", 64'(imem_req_valid), 64'd0);
      chk("rst2_fetch_pc", imem_req_addr, RST_PC);
`ifdef FETCH_PERF_COUNTERS_EN
      chk("rst2_starve", 64'(perf_starve_cycles), 64'd0);
      chk("rst2_stall", 64'(perf_stall_cycles), 64'd0);
`endif
      lat_min = 1; lat_max = 1;
      repeat (10) step(1'b0, 1'b0, 64'd0, 1'b1, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
- Parametrised instruction-fetch front end.
- Holds the fetch PC and issues pipelined requests to instruction memory over a valid/ready interface.
- Buffers returned instructions with their PCs in a FIFO and presents them to decode over a valid/ready handshake.
- Supports redirect (branch/jump) with a flush of buffered and in-flight fetches.

Parameters:
- XLEN, 64, address/PC width.
- ILEN, 32, instruction width.
- FIFO_DEPTH, 4, instruction queue entries; power of two, >= 2.
- MAX_OUTSTANDING, 2, maximum issued-but-unanswered memory requests; >= 1.
- RESET_PC, 0, fetch PC loaded on reset.

Ports:
- clk, input, 1, clock; reset rst, synchronous, active-high; clock clk.
- rst, input, 1, synchronous active-high reset.
- redirect_valid, input, 1, load new fetch PC and flush.
- redirect_pc, input, XLEN, redirect target.
- imem_req_valid, output, 1, fetch request valid.
- imem_req_ready, input, 1, memory accepts request.
- imem_req_addr, output, XLEN, fetch address.
- imem_resp_valid, input, 1, response valid; in order, >= 1 cycle after acceptance.
- imem_resp_data, input, ILEN, fetched instruction.
- out_valid, output, 1, queue head valid.
- out_ready, input, 1, decode consumes head.
- out_pc, output, XLEN, PC of head instruction.
- out_instr, output, ILEN, head instruction.

Behaviour:
- Reset: fetch_pc = RESET_PC, FIFO empty, outstanding = 0, drop = 0, imem_req_valid = 0, out_valid = 0, out_pc = 0, out_instr = 0. Reset mid-operation discards all state; the memory is reset in the same cycle.
- Issue:
  - imem_req_valid = !rst & !redirect_valid & (outstanding < MAX_OUTSTANDING) & (fifo_count + outstanding + drop < FIFO_DEPTH), using registered values only (no same-cycle pop credit).
  - imem_req_addr = fetch_pc.
  - On fire (valid & ready): fetch_pc <= fetch_pc + 4, wrapping modulo 2^XLEN. Issued PC is pushed to an internal PC tag queue of MAX_OUTSTANDING entries.
- Response:
  - If drop > 0: the response is discarded and drop decrements.
  - Otherwise {tag_pc, imem_resp_data} is pushed to the FIFO and outstanding decrements.
  - FIFO overflow is impossible by the credit rule. A response with nothing in flight is a protocol error and is ignored.
- Output:
  - out_valid = FIFO non-empty; out_pc/out_instr show the head combinationally from FIFO storage.
  - Pop when out_valid & out_ready. Push and pop in the same cycle leave the count unchanged. Data holds stable while valid & !ready.
- Redirect (priority over everything except rst):
  - At the clock edge: FIFO cleared and fetch_pc <= redirect_pc.
  - drop <= drop + outstanding - (response arriving this cycle ? 1 : 0); outstanding <= 0; tag queue cleared.
  - No request is issued in the redirect cycle. Any pop or response in that cycle has no effect beyond the flush.
  - First request at redirect_pc issues the next cycle, subject to credit.
  - Back-to-back redirects: the last one wins.
- Latency: with a 1-cycle memory and an empty queue, an instruction reaches out_valid 2 cycles after request fire.
- Steady state (memory always ready, 1-cycle latency, decode always ready, MAX_OUTSTANDING >= 2): one instruction per cycle.

Optional Feature:
- Macro: FETCH_PERF_COUNTERS_EN.
- When defined, adds output perf_starve_cycles [31:0] and output perf_stall_cycles [31:0], both reset to 0, saturating at 2^32-1:
  - perf_starve_cycles counts cycles with out_ready & !out_valid.
  - perf_stall_cycles counts cycles with imem_req_valid & !imem_req_ready.
- When undefined, the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset release, memory 1-cycle, ready always 1, out_ready=1 -> requests at 0x0,0x4,0x8,...; out_pc 0x0 then 0x4 on consecutive cycles; out_instr matches memory.
- out_ready=0 for 10 cycles -> FIFO fills to FIFO_DEPTH=4 (PCs 0x0-0xC) and imem_req_valid drops to 0. Raising out_ready drains in order and fetch resumes at 0x10.
- Redirect to 0x100 with 2 requests in flight -> both late responses dropped (never appear on out_*), next out_pc = 0x100, no request in the redirect cycle.
- imem_req_ready low for 3 cycles -> imem_req_addr held constant; fetch_pc unchanged; no duplicate or skipped PC afterwards.
- RESET_PC = 2^XLEN-4 -> second request address 0x0 (wrap).
- Assert rst with full FIFO and 2 outstanding -> next cycle out_valid=0, imem_req_valid=0; after release fetch restarts at RESET_PC. With FETCH_PERF_COUNTERS_EN, counters read 0.
